input_debounce_2ch: RTL and testbench

//  Two-channel input conditioner that sits directly upstream of the 2-input gate labs
//  (De Morgan / NAND-equivalent stages) and produces their a/b operands.

---
 rtl/debounce_pkg.sv | 21 ++
 rtl/debounce_ch.sv | 145 ++++++++++++++
 rtl/input_debounce_2ch.sv | 74 +++++++
 tb/tb_input_debounce_2ch.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_pkg
//  Description : Shared constants for the input debouncer: FSM state
//                encoding and default parameter values.
//                No ports (package).
//  Revision    : 1.0  initial release
// ============================================================================
package debounce_pkg;

    // FSM state encoding, shared by every channel instance
    localparam logic [0:0] IDLE  = 1'b0;   // synchronised level equals output
    localparam logic [0:0] COUNT = 1'b1;   // level differs, qualifying

    // Default build-time configuration
    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 1000000;
    localparam int CNT_W_DEF           = 20;

endpackage
`default_nettype wire

// File: rtl/debounce_ch.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_ch
//  Description : One debounce channel: SYNC_STAGES-deep synchroniser, a
//                two-state qualification FSM and a stability counter.
//                The output level changes only after the synchronised input
//                has differed from it for DEBOUNCE_CYCLES consecutive cycles.
//  Ports       : clk   in   system clock
//                rst   in   synchronous active-high reset
//                raw   in   asynchronous raw level
//                db    out  debounced level (registered)
//                rise  out  one-cycle pulse after db goes 0->1  (EDGE_PULSE_EN)
//                fall  out  one-cycle pulse after db goes 1->0  (EDGE_PULSE_EN)
//  Config      : define EDGE_PULSE_EN to build the edge-pulse outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module debounce_ch
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic db
`ifdef EDGE_PULSE_EN
    ,
    output logic rise,
    output logic fall
`endif
);

    // Last count value before the output is allowed to flip
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;
    logic [0:0]             r_state;
    logic [0:0]             w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   r_db;
    logic                   w_db_nxt;

    // ------------------------------------------------------------------
    // Synchroniser: raw enters at bit 0, synchronised level leaves the MSB
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], raw};
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // State register (state, counter and debounced level)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_db    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_db    <= w_db_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // The IDLE->COUNT transition already accounts for the first differing
    // cycle (cnt starts at 1), so the flip happens when cnt reaches
    // DEBOUNCE_CYCLES-1 with the level still differing. cnt is bounded by
    // that value and can never wrap.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_db_nxt    = r_db;
        case (r_state)
            IDLE: begin
                if (w_s != r_db) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        // Single-cycle qualification: flip immediately
                        w_db_nxt = w_s;
                    end else begin
                        w_cnt_nxt   = c_cnt_one;
                        w_state_nxt = COUNT;
                    end
                end
            end
            COUNT: begin
                if (w_s == r_db) begin
                    // Bounce: level returned, restart qualification
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end else if (r_cnt == c_cnt_last) begin
                    w_db_nxt    = w_s;
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

`ifdef EDGE_PULSE_EN
    // Delayed copy of db; edges are a compare of two registers, so the
    // pulses are glitch-free and last exactly one cycle.
    logic r_db_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_db_d <= 1'b0;
        end else begin
            r_db_d <= r_db;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        db = r_db;
`ifdef EDGE_PULSE_EN
        rise = r_db & ~r_db_d;
        fall = ~r_db & r_db_d;
`endif
    end

endmodule
`default_nettype wire

// File: rtl/input_debounce_2ch.sv
`default_nettype none
// ============================================================================
//  Module      : input_debounce_2ch
//  Description : Two independent debounce channels producing the clean a/b
//                operands for the downstream 2-input gate stages.
//  Ports       : clk     in   system clock
//                rst     in   synchronous active-high reset
//                a_raw   in   raw level, channel A
//                b_raw   in   raw level, channel B
//                a_db    out  debounced level A
//                b_db    out  debounced level B
//                a_rise  out  pulse after a_db 0->1   (EDGE_PULSE_EN)
//                a_fall  out  pulse after a_db 1->0   (EDGE_PULSE_EN)
//                b_rise  out  pulse after b_db 0->1   (EDGE_PULSE_EN)
//                b_fall  out  pulse after b_db 1->0   (EDGE_PULSE_EN)
//  Config      : define EDGE_PULSE_EN to build the edge-pulse outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module input_debounce_2ch
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic a_raw,
    input  logic b_raw,
    output logic a_db,
    output logic b_db
`ifdef EDGE_PULSE_EN
    ,
    output logic a_rise,
    output logic a_fall,
    output logic b_rise,
    output logic b_fall
`endif
);

    debounce_ch #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_ch_a (
        .clk  (clk),
        .rst  (rst),
        .raw  (a_raw),
        .db   (a_db)
`ifdef EDGE_PULSE_EN
        ,
        .rise (a_rise),
        .fall (a_fall)
`endif
    );

    debounce_ch #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_ch_b (
        .clk  (clk),
        .rst  (rst),
        .raw  (b_raw),
        .db   (b_db)
`ifdef EDGE_PULSE_EN
        ,
        .rise (b_rise),
        .fall (b_fall)
`endif
    );

endmodule
`default_nettype wire

// File: tb/tb_input_debounce_2ch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_input_debounce_2ch
//  Description : Self-checking bench for input_debounce_2ch with
//                SYNC_STAGES=2, DEBOUNCE_CYCLES=4, CNT_W=3. A behavioural
//                model derives the debounced levels from the history of
//                sampled raw values; directed tables and sequences add
//                explicit expected values for the corner cases.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_input_debounce_2ch;

    localparam int SS   = 2;
    localparam int DC   = 4;
    localparam int CW   = 3;
    localparam int MAXT = 8192;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a_raw = 1'b0;
    logic b_raw = 1'b0;
    logic a_db;
    logic b_db;
`ifdef EDGE_PULSE_EN
    logic a_rise, a_fall, b_rise, b_fall;
`endif

    input_debounce_2ch #(
        .SYNC_STAGES     (SS),
        .DEBOUNCE_CYCLES (DC),
        .CNT_W           (CW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .a_raw  (a_raw),
        .b_raw  (b_raw),
        .a_db   (a_db),
        .b_db   (b_db)
`ifdef EDGE_PULSE_EN
        ,
        .a_rise (a_rise),
        .a_fall (a_fall),
        .b_rise (b_rise),
        .b_fall (b_fall)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ------------------------------------------------------------------
    // Reference model: raw samples per edge since reset; the synchronised
    // level seen at an edge is the raw value sampled SS edges earlier.
    // The output flips when the last DC synchronised values (all taken
    // since the previous flip) differ from the current output.
    // ------------------------------------------------------------------
    bit raw_hist [2][MAXT];
    bit s_hist   [2][MAXT];
    int n_edges;
    int win_start [2];
    bit m_db   [2];
    bit m_rise [2];
    bit m_fall [2];

    task automatic model_edge(input bit r, input bit ra, input bit rb);
        bit raw_v, s_v, prev, qual;
        if (r || n_edges >= MAXT) begin
            n_edges = 0;
            for (int c = 0; c < 2; c++) begin
                win_start[c] = 0;
                m_db[c]      = 1'b0;
                m_rise[c]    = 1'b0;
                m_fall[c]    = 1'b0;
            end
            if (r) return;
        end
        for (int c = 0; c < 2; c++) begin
            raw_v = (c == 0) ? ra : rb;
            s_v   = (n_edges >= SS) ? raw_hist[c][n_edges-SS] : 1'b0;
            s_hist[c][n_edges]   = s_v;
            raw_hist[c][n_edges] = raw_v;
            prev = m_db[c];
            qual = (n_edges - DC + 1 >= win_start[c]);
            if (qual) begin
                for (int k = n_edges - DC + 1; k <= n_edges; k++) begin
                    if (s_hist[c][k] == m_db[c]) qual = 1'b0;
                end
            end
            if (qual) begin
                m_db[c]      = ~m_db[c];
                win_start[c] = n_edges + 1;
            end
            m_rise[c] = !prev && m_db[c];
            m_fall[c] = prev && !m_db[c];
        end
        n_edges++;
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0b expected %0b", name, $time, act, exp);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, compare after it
    task automatic tick(input bit r, input bit ra, input bit rb);
        rst   = r;
        a_raw = ra;
        b_raw = rb;
        @(posedge clk);
        model_edge(r, ra, rb);
        #1;
        chk("model_a_db", a_db, m_db[0]);
        chk("model_b_db", b_db, m_db[1]);
`ifdef EDGE_PULSE_EN
        chk("model_a_rise", a_rise, m_rise[0]);
        chk("model_a_fall", a_fall, m_fall[0]);
        chk("model_b_rise", b_rise, m_rise[1]);
        chk("model_b_fall", b_fall, m_fall[1]);
`endif
    endtask

    typedef struct {
        bit rst;
        bit a;
        bit b;
        bit ea;
        bit eb;
        bit er;   // expected a_rise
    } vec_t;

    vec_t vt[$];

    function automatic void addv(input bit r, input bit a, input bit b,
                                 input bit ea, input bit eb, input bit er);
        vec_t v;
        v.rst = r; v.a = a; v.b = b; v.ea = ea; v.eb = eb; v.er = er;
        vt.push_back(v);
    endfunction

    initial begin
        // Reset with both raw inputs high, then quiet, then a clean A step
        for (int i = 0; i < 3; i++) addv(1, 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) addv(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) addv(0, 1, 0, 0, 0, 0);
        addv(0, 1, 0, 1, 0, 1);
        for (int i = 0; i < 2; i++) addv(0, 1, 0, 1, 0, 0);

        for (int i = 0; i < vt.size(); i++) begin
            tick(vt[i].rst, vt[i].a, vt[i].b);
            chk("tbl_a_db", a_db, vt[i].ea);
            chk("tbl_b_db", b_db, vt[i].eb);
`ifdef EDGE_PULSE_EN
            chk("tbl_a_rise", a_rise, vt[i].er);
            chk("tbl_edges_quiet", a_fall | b_rise | b_fall, 1'b0);
`endif
        end

        // Bounce on A: bring a_db low, then 1,0,1,1,0 and hold 1
        for (int i = 0; i < 8; i++) tick(0, 0, 0);
        chk("bounce_pre_low", a_db, 1'b0);
        begin
            bit pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
            for (int i = 0; i < 5; i++) begin
                tick(0, pat[i], 0);
                chk("bounce_no_early", a_db, 1'b0);
            end
        end
        for (int i = 0; i < 8; i++) begin
            tick(0, 1, 0);
            chk("bounce_hold_a_db", a_db, (i >= 5));
        end

        // Short glitch on B: b_db high, then 3 low cycles
        for (int i = 0; i < 8; i++) tick(0, 1, 1);
        chk("glitch_pre_b_db", b_db, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(0, 1, 0);
            chk("glitch_b_db_low", b_db, 1'b1);
`ifdef EDGE_PULSE_EN
            chk("glitch_no_fall", b_fall, 1'b0);
`endif
        end
        for (int i = 0; i < 8; i++) begin
            tick(0, 1, 1);
            chk("glitch_b_db_hold", b_db, 1'b1);
`ifdef EDGE_PULSE_EN
            chk("glitch_no_fall", b_fall, 1'b0);
`endif
        end

        // Simultaneous fall on both channels
        for (int i = 0; i < 8; i++) begin
            tick(0, 0, 0);
            chk("simul_a_db", a_db, (i < 5));
            chk("simul_b_db", b_db, (i < 5));
        end

        // Reset in the middle of an A qualification
        for (int i = 0; i < 4; i++) tick(0, 1, 0);
        tick(1, 1, 0);
        chk("midrst_a_db", a_db, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick(0, 1, 0);
            chk("midrst_requal", a_db, (i >= 5));
        end

        // Randomised stimulus against the model
        begin
            bit ra = 1'b1;
            bit rb = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 7) == 0) ra = ~ra;
                if ($urandom_range(0, 6) == 0) rb = ~rb;
                tick(($urandom_range(0, 299) == 0), ra, rb);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
